fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - Producer side of the IF/ID register: owns the PC and the instruction-memory handshake.
//  - Drives PC (= fetch address + PC_STEP) and the instruction word into IF/ID every cycle.
//  - Honours freeze from the hazard unit and redirects on branchTaken from EXE.
//  - Emits an all-zero NOP bubble whenever no fetched word is available.
// PARAMETERS
//  - WORD_LEN  `WORD_LEN (32)  width of PC, address and instruction
//  - RESET_PC  0               fetch address after reset
//  - PC_STEP   4               increment applied after each accepted fetch
// PORTS
//  - clk          in   1         clock, rising edge
//  - rst          in   1         asynchronous, active-high reset
//  - freeze       in   1         IF/ID frozen; current word must not be consumed
//  - branchTaken  in   1         redirect fetch to branchAddr (priority over freeze)
//  - branchAddr   in   WORD_LEN  redirect target
//  - imemReq      out  1         fetch request, held high until imemAck
//  - imemAddr     out  WORD_LEN  fetch address, stable while imemReq && !imemAck
//  - imemAck      in   1         memory returns imemData this cycle
//  - imemData     in   WORD_LEN  instruction word, valid with imemAck
//  - PC           out  WORD_LEN  fetch address + PC_STEP, to IF/ID PCIn
//  - instruction  out  WORD_LEN  fetched word or 0 (bubble), to IF/ID instructionIn
//  - instrValid   out  1         instruction carries a real fetched word this cycle
// BEHAVIOUR
//  - Registers: pcReg (fetch address), tgtReg (pending target), state in {WAIT, DISCARD, HOLD}.
//  - Reset: pcReg=RESET_PC, tgtReg=0, state=WAIT.
//  - Reset values of outputs: imemReq=0 while rst high; instruction=0, instrValid=0, PC=RESET_PC+PC_STEP.
//  - imemReq=1 in WAIT/DISCARD, 0 in HOLD.
//  - imemAddr=pcReg in all states; in DISCARD pcReg still holds the stale address.
//  - Output path is combinational from the ack; no extra latency (IF/ID supplies the register stage).
//  - WAIT, no imemAck: instruction=0, instrValid=0. On branchTaken: tgtReg<=branchAddr, go DISCARD.
//  - WAIT, imemAck, !branchTaken, !freeze: instruction=imemData, instrValid=1, pcReg<=pcReg+PC_STEP, stay WAIT.
//    Back-to-back: request stays high at the new address next cycle.
//  - WAIT, imemAck, branchTaken: word dropped (instruction=0), pcReg<=branchAddr, stay WAIT.
//  - WAIT, imemAck, freeze, !branchTaken: see CONFIGURATION.
//  - DISCARD: instruction=0, instrValid=0.
//    branchTaken: tgtReg<=branchAddr (latest wins).
//    imemAck: pcReg<=(branchTaken ? branchAddr : tgtReg), go WAIT.
//  - PC output = pcReg+PC_STEP, truncated to WORD_LEN (wraps at 2^WORD_LEN).
//  - branchAddr is used verbatim; no alignment forcing.
//  - rst asserted mid-transaction: state and pcReg reset at once; any in-flight ack is ignored.
// CONFIGURATION
//  - FETCH_BUF_EN defined: 1-entry hold buffer bufReg.
//    WAIT+imemAck+freeze+!branchTaken: bufReg<=imemData, go HOLD, pcReg unchanged.
//    HOLD: instruction=bufReg, instrValid=1, imemReq=0.
//    HOLD, freeze low: pcReg<=pcReg+PC_STEP, go WAIT.
//    HOLD, branchTaken (any freeze): buffer dropped, pcReg<=branchAddr, go WAIT.
//  - FETCH_BUF_EN undefined: no HOLD state.
//    WAIT+imemAck+freeze: instruction=imemData, instrValid=1, pcReg unchanged, stay WAIT.
//    The same address is refetched until an ack arrives with freeze low.
// TESTING
//  - Reset release, imemAck tied 1, imemData=addr:
//    imemAddr 0,4,8,12; PC 4,8,12,16; instrValid=1 from the first cycle.
//  - imemAck with 2-cycle latency:
//    imemAddr stable for 3 cycles; instruction=0 and instrValid=0 on non-ack cycles.
//  - branchTaken (branchAddr=0x40) while waiting on addr 8:
//    DISCARD; imemAddr stays 8 until ack; that word dropped; next request 0x40; PC=0x44.
//  - branchTaken coincident with imemAck at addr 8:
//    instruction=0; next imemAddr=0x40.
//  - freeze high 3 cycles at addr 0x10, ack always 1:
//    without FETCH_BUF_EN, imemAddr=0x10 repeated;
//    with FETCH_BUF_EN, imemReq=0, instruction=buffered word; 0x14 fetched after release.
//  - rst pulsed while in DISCARD:
//    imemReq=0 during rst; first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and imem requester for IF/ID; zero-latency ack-to-instruction path, freeze stalls consumption.
// Optional macro FETCH_BUF_EN adds a one-word hold buffer so a frozen pipeline stops refetching the same address.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module fetch_stage #(
  parameter int                  WORD_LEN = `WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] PC_STEP  = WORD_LEN'(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branchTaken,
  input  logic [WORD_LEN-1:0] branchAddr,
  output logic                imemReq,
  output logic [WORD_LEN-1:0] imemAddr,
  input  logic                imemAck,
  input  logic [WORD_LEN-1:0] imemData,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                instrValid
);

`ifdef FETCH_BUF_EN
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_DISCARD = 2'd1, S_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_DISCARD = 2'd1} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [WORD_LEN-1:0] r_pc, w_pc_nxt;
  logic [WORD_LEN-1:0] r_tgt, w_tgt_nxt;
  logic [WORD_LEN-1:0] w_instr;
  logic                w_req, w_valid;
`ifdef FETCH_BUF_EN
  logic [WORD_LEN-1:0] r_buf, w_buf_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
`ifdef FETCH_BUF_EN
      r_buf   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
`ifdef FETCH_BUF_EN
      r_buf   <= w_buf_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_req       = 1'b1;
    w_instr     = '0;
    w_valid     = 1'b0;
`ifdef FETCH_BUF_EN
    w_buf_nxt   = r_buf;
`endif
    case (r_state)
      S_WAIT: begin
        if (imemAck) begin
          if (branchTaken) begin
            w_pc_nxt = branchAddr;
          end else begin
            w_instr = imemData;
            w_valid = 1'b1;
            if (!freeze) begin
              w_pc_nxt = r_pc + PC_STEP;
            end
`ifdef FETCH_BUF_EN
            else begin
              w_buf_nxt   = imemData;
              w_state_nxt = S_HOLD;
            end
`endif
          end
        end else if (branchTaken) begin
          w_tgt_nxt   = branchAddr;
          w_state_nxt = S_DISCARD;
        end
      end
      // The in-flight request to the stale address must complete before redirecting.
      S_DISCARD: begin
        if (branchTaken) begin
          w_tgt_nxt = branchAddr;
        end
        if (imemAck) begin
          w_pc_nxt    = branchTaken ? branchAddr : r_tgt;
          w_state_nxt = S_WAIT;
        end
      end
`ifdef FETCH_BUF_EN
      S_HOLD: begin
        w_req = 1'b0;
        if (branchTaken) begin
          w_pc_nxt    = branchAddr;
          w_state_nxt = S_WAIT;
        end else begin
          w_instr = r_buf;
          w_valid = 1'b1;
          if (!freeze) begin
            w_pc_nxt    = r_pc + PC_STEP;
            w_state_nxt = S_WAIT;
          end
        end
      end
`endif
      default: w_state_nxt = S_WAIT;
    endcase
  end

  assign imemReq     = w_req & ~rst;
  assign imemAddr    = r_pc;
  assign PC          = r_pc + PC_STEP;
  assign instruction = rst ? '0 : w_instr;
  assign instrValid  = w_valid & ~rst;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (fetch address, pending redirect, held word).
module tb_fetch_stage;
  localparam int         W    = 32;
  localparam logic [W-1:0] STEP = 32'd4;
`ifdef FETCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, freeze, branchTaken, imemAck;
  logic [W-1:0] branchAddr, salt;
  logic         imemReq, instrValid;
  logic [W-1:0] imemAddr, imemData, PC, instruction;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imemData = imemAddr + salt;

  fetch_stage #(.WORD_LEN(W), .RESET_PC(32'd0), .PC_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken), .branchAddr(branchAddr),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .PC(PC), .instruction(instruction), .instrValid(instrValid)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: where the next fetch goes, whether the outstanding word is unwanted, and any held word.
  logic [W-1:0] m_pc = '0, m_tgt = '0, m_buf = '0;
  bit           m_drop = 1'b0, m_held = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_tgt = '0; m_drop = 1'b0; m_held = 1'b0;
    end else if (m_held) begin
      if (branchTaken) begin m_pc = branchAddr; m_held = 1'b0; end
      else if (!freeze) begin m_pc = m_pc + STEP; m_held = 1'b0; end
    end else if (m_drop) begin
      if (branchTaken) m_tgt = branchAddr;
      if (imemAck) begin m_pc = m_tgt; m_drop = 1'b0; end
    end else if (imemAck) begin
      if (branchTaken) m_pc = branchAddr;
      else if (!freeze) m_pc = m_pc + STEP;
      else if (BUF) begin m_buf = m_pc + salt; m_held = 1'b1; end
    end else if (branchTaken) begin
      m_tgt = branchAddr; m_drop = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e_addr, e_ins;
    logic         e_req, e_val;
    e_addr = '0; e_ins = '0; e_req = 1'b0; e_val = 1'b0;
    if (!rst) begin
      e_addr = m_pc;
      e_req  = !m_held;
      if (m_held) begin
        if (!branchTaken) begin e_ins = m_buf; e_val = 1'b1; end
      end else if (!m_drop && imemAck && !branchTaken) begin
        e_ins = m_pc + salt; e_val = 1'b1;
      end
    end
    chk("model_req",   32'(imemReq),    32'(e_req));
    chk("model_addr",  imemAddr,        e_addr);
    chk("model_pc",    PC,              e_addr + STEP);
    chk("model_instr", instruction,     e_ins);
    chk("model_valid", 32'(instrValid), 32'(e_val));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    freeze = 1'b0; branchTaken = 1'b0; imemAck = 1'b0; branchAddr = '0; salt = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_req",   32'(imemReq),    32'd0);
    chk("rst_instr", instruction,     32'd0);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_pc",    PC,              32'd4);
    cyc();

    // Ack tied high, back-to-back fetches.
    rst = 1'b0; imemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_addr",  imemAddr,        32'(i * 4));
      chk("b2b_pc",    PC,              32'(i * 4 + 4));
      chk("b2b_valid", 32'(instrValid), 32'd1);
      chk("b2b_instr", instruction,     32'(i * 4));
      cyc();
    end

    // Two-cycle memory latency at address 16.
    for (int i = 0; i < 3; i++) begin
      imemAck = (i == 2);
      @(negedge clk);
      chk("lat_addr",  imemAddr,        32'd16);
      chk("lat_valid", 32'(instrValid), (i == 2) ? 32'd1 : 32'd0);
      chk("lat_instr", instruction,     (i == 2) ? 32'd16 : 32'd0);
      cyc();
    end

    // Redirect while waiting on address 8.
    do_reset();
    imemAck = 1'b1; cyc(); cyc();
    imemAck = 1'b0; branchTaken = 1'b1; branchAddr = 32'h40;
    @(negedge clk);
    chk("bw_addr0", imemAddr, 32'd8);
    chk("bw_val0",  32'(instrValid), 32'd0);
    cyc();
    branchTaken = 1'b0;
    @(negedge clk);
    chk("bw_addr1", imemAddr, 32'd8);
    chk("bw_req1",  32'(imemReq), 32'd1);
    cyc();
    imemAck = 1'b1;
    @(negedge clk);
    chk("bw_drop_val",   32'(instrValid), 32'd0);
    chk("bw_drop_instr", instruction,     32'd0);
    cyc();
    imemAck = 1'b0;
    @(negedge clk);
    chk("bw_new_addr", imemAddr, 32'h40);
    chk("bw_new_pc",   PC,       32'h44);
    cyc();

    // Redirect coincident with ack at address 8.
    do_reset();
    imemAck = 1'b1; cyc(); cyc();
    branchTaken = 1'b1; branchAddr = 32'h40;
    @(negedge clk);
    chk("ba_instr", instruction,     32'd0);
    chk("ba_valid", 32'(instrValid), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("ba_next_addr", imemAddr, 32'h40);
    cyc();

    // Freeze for three cycles at 0x10 with ack always high.
    do_reset();
    imemAck = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_addr",  imemAddr,    32'h10);
      chk("frz_req",   32'(imemReq), (BUF && i > 0) ? 32'd0 : 32'd1);
      chk("frz_instr", instruction, 32'h10);
      cyc();
    end
    freeze = 1'b0;
    @(negedge clk);
    chk("frz_rel_instr", instruction, 32'h10);
    cyc();
    @(negedge clk);
    chk("frz_next_addr", imemAddr,     32'h14);
    chk("frz_next_req",  32'(imemReq), 32'd1);
    cyc();

    // Reset pulsed while discarding.
    do_reset();
    imemAck = 1'b1; cyc();
    imemAck = 1'b0; branchTaken = 1'b1; branchAddr = 32'h80; cyc();
    branchTaken = 1'b0;
    @(negedge clk);
    chk("rd_disc_addr", imemAddr, 32'd4);
    cyc();
    rst = 1'b1; imemAck = 1'b1;
    @(negedge clk);
    chk("rd_req0", 32'(imemReq),    32'd0);
    chk("rd_val0", 32'(instrValid), 32'd0);
    cyc();
    @(negedge clk);
    chk("rd_req1", 32'(imemReq), 32'd0);
    cyc();
    rst = 1'b0; imemAck = 1'b0;
    @(negedge clk);
    chk("rd_rel_addr", imemAddr,     32'd0);
    chk("rd_rel_req",  32'(imemReq), 32'd1);
    cyc();

    // Randomized traffic, including unaligned and wrapping redirect targets.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      rst         = ($urandom_range(0, 199) == 0);
      freeze      = ($urandom_range(0, 9) < 3);
      branchTaken = ($urandom_range(0, 9) == 0);
      imemAck     = $urandom_range(0, 1) == 1;
      salt        = $urandom;
      sel         = $urandom_range(0, 3);
      if (sel == 0)      branchAddr = 32'hFFFF_FFFC;
      else if (sel == 1) branchAddr = $urandom;
      else               branchAddr = 32'($urandom_range(0, 255)) << 2;
      cyc();
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
